load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised memory-access controller between the execute stage and the data memory port of the core. It replaces the single-cycle `mem_read`/`mem_write`/`wr_en`/`rd_en` path of the control unit with a handshaked, multi-cycle access supporting XLEN 32/64, byte/half/word(/double) lanes, sign/zero extension, misalignment detection and a bus timeout. It stalls the pipeline while an access is outstanding and returns load data to writeback.

## Interface
- `XLEN`, 32: data/address width; 32 or 64.
- `TIMEOUT`, 16: max cycles waiting for `mem_ready` before an access fault; 0 disables the timeout.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  execute stage presents a load/store.
- `req_ready`  out  1  LSU can accept a request (state IDLE).
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_func3`  in  3  RISC-V width/sign field.
- `req_addr`  in  XLEN  effective byte address.
- `req_wdata`  in  XLEN  store data, LSB-aligned.
- `req_rd`  in  5  load destination register.
- `stall`  out  1  hold upstream pipeline.
- `mem_addr`  out  XLEN  address aligned down to XLEN/8 bytes.
- `mem_wdata`  out  XLEN  lane-shifted store data.
- `mem_wstrb`  out  XLEN/8  byte-lane write enables.
- `mem_rd_en`, `mem_wr_en`  out  1  access request, held until `mem_ready`.
- `mem_ready`  in  1  memory completes access this cycle.
- `mem_rdata`  in  XLEN  read data, valid with `mem_ready`.
- `wb_valid`  out  1  one-cycle pulse: load result valid.
- `wb_rd`  out  5  / `wb_data`  out  XLEN  load destination and extended data.
- `exc_valid`  out  1  one-cycle exception pulse.
- `exc_cause`  out  4  2 illegal, 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault.
- `exc_addr`  out  XLEN  faulting `req_addr`.

## Operation
- func3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only, load only). Any other code, and any unsigned code on a store, is illegal.
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`: illegal → `exc_valid` cause 2, stay IDLE. Misaligned (address not a multiple of the access size) → cause 4/6, stay IDLE. Otherwise latch the request and go to ACCESS.
  - ACCESS: drive `mem_rd_en` or `mem_wr_en` together with the latched address, data and strobes, all held stable. On `mem_ready`: for a load, register extended data into `wb_data` and pulse `wb_valid`; for a store, no writeback. Then go to IDLE.
  - Timeout: a counter clears on entry to ACCESS. When it reaches `TIMEOUT` with no `mem_ready`: pulse cause 5/7, drop the enables, go to IDLE.
- Store lanes: offset = `req_addr[log2(XLEN/8)-1:0]`. `mem_wdata` = `req_wdata` << 8·offset. `mem_wstrb` = size mask << offset.
- Loads: the selected lane is shifted down, then sign- or zero-extended to XLEN.
- `stall` = (state != IDLE) | (`req_valid` & exception this cycle).
- `exc_valid` and `wb_valid` are never asserted in the same cycle.
- `mem_rdata` is ignored except in an ACCESS cycle with `mem_ready`=1.
- `mem_ready` seen in IDLE is ignored.

## Timing
- Request accepted at cycle 0. Enables assert at cycle 1 (registered).
- If `mem_ready` is high at cycle 1, `wb_valid` pulses at cycle 2 and `req_ready`=1 at cycle 2, so back-to-back accepts are possible every 2 cycles.
- Exceptions pulse in cycle 1 after the offending request. No memory enable is ever asserted for a faulting request.
- Timeout fault pulses the cycle after the counter hits `TIMEOUT`. Enables are low in that same cycle.
- Reset (asynchronous, any state) forces: state IDLE; all enables, `wb_valid`, `exc_valid` and `stall` to 0; `req_ready`=1; data/address outputs 0. An in-flight access is abandoned with no writeback and no exception.

## Structure
- Package `lsu_pkg`: state enum, func3 constants, exception cause constants, size-decode function.
- One sub-module, `lsu_align`: combinational store shift/strobe generation and load extract/extend, parametrised by XLEN.
- `load_store_unit` holds the FSM, timeout counter and output registers.

## Test plan
- SW, addr 0x100, data 0xDEADBEEF, `mem_ready` at cycle 1 → `mem_addr` 0x100, `wstrb` 4'b1111, `wdata` 0xDEADBEEF, `mem_wr_en` high for exactly 1 cycle, no `wb_valid`.
- LB addr 0x103 with `mem_rdata` 0x80FF0000 → `wb_data` 0xFFFFFF80. LBU on the same access → 0x00000080.
- SH addr 0x202, data 0x1234ABCD → `mem_addr` 0x200, `wstrb` 4'b1100, `wdata` 0xABCD0000.
- LH addr 0x101 → `exc_valid` with cause 4, `exc_addr` 0x101, no `mem_rd_en`. Same for SW at 0x102 → cause 6.
- TIMEOUT=8, `mem_ready` held low on a load → cause 5 after 8 ACCESS cycles, enables drop, `req_ready` returns to 1.
- Reset pulse during ACCESS → `mem_rd_en` low asynchronously; after release `req_ready`=1 and no `wb_valid` ever appears. With XLEN=64, LD at 0x08 returns the full 64-bit `mem_rdata`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, func3/cause encodings and access-size decode for the load/store unit.
package lsu_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    // log2 of the access size in bytes
    function automatic logic [1:0] f3_size(input logic [2:0] func3);
        case (func3)
            F3_B, F3_BU: f3_size = 2'd0;
            F3_H, F3_HU: f3_size = 2'd1;
            F3_W, F3_WU: f3_size = 2'd2;
            default:     f3_size = 2'd3;
        endcase
    endfunction

    function automatic logic f3_legal(input logic [2:0] func3,
                                      input logic       is_store,
                                      input logic       xlen64);
        case (func3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_D:             f3_legal = xlen64;
            F3_BU, F3_HU:     f3_legal = ~is_store;
            F3_WU:            f3_legal = xlen64 & ~is_store;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store data/strobe shift-up and load lane extract with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 st_func3,
    input  logic [$clog2(XLEN/8)-1:0]  st_offset,
    input  logic [XLEN-1:0]            st_wdata,
    output logic [XLEN-1:0]            st_data,
    output logic [XLEN/8-1:0]          st_strb,
    input  logic [2:0]                 ld_func3,
    input  logic [$clog2(XLEN/8)-1:0]  ld_offset,
    input  logic [XLEN-1:0]            ld_rdata,
    output logic [XLEN-1:0]            ld_data
);
    localparam int NB = XLEN / 8;

    logic [1:0]      st_size_s;
    logic [NB-1:0]   base_mask_s;
    logic [1:0]      ld_size_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] keep_s;
    logic            sign_s;
    logic            fill_s;

    // Store: size mask and data both move up by the byte offset
    always_comb begin
        st_size_s   = f3_size(st_func3);
        base_mask_s = ~({NB{1'b1}} << (4'd1 << st_size_s));
        st_strb     = base_mask_s << st_offset;
        st_data     = st_wdata << {st_offset, 3'b000};
    end

    // Load: bring the lane down to bit 0, keep its bytes, fill the rest with sign or zero
    always_comb begin
        ld_size_s = f3_size(ld_func3);
        shifted_s = ld_rdata >> {ld_offset, 3'b000};
        case (ld_size_s)
            2'd0: begin
                keep_s = XLEN'(8'hFF);
                sign_s = shifted_s[7];
            end
            2'd1: begin
                keep_s = XLEN'(16'hFFFF);
                sign_s = shifted_s[15];
            end
            2'd2: begin
                keep_s = XLEN'(32'hFFFF_FFFF);
                sign_s = shifted_s[31];
            end
            default: begin
                keep_s = {XLEN{1'b1}};
                sign_s = shifted_s[XLEN-1];
            end
        endcase
        fill_s  = sign_s & ~ld_func3[2];
        ld_data = (shifted_s & keep_s) | ({XLEN{fill_s}} & ~keep_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked multi-cycle load/store controller between execute and the data memory port.
// Two-state FSM with a bus timeout; every output except stall comes straight from a register.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_func3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              exc_valid,
    output logic [3:0]        exc_cause,
    output logic [XLEN-1:0]   exc_addr
);
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    lsu_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic            is_store_r;
    logic [2:0]      func3_r;
    logic [XLEN-1:0] addr_r;
    logic [4:0]      rd_r;

    logic [1:0]       size_s;
    logic             legal_s;
    logic             misalign_s;
    logic             fault_s;
    logic             timeout_hit_s;
    logic [XLEN-1:0]  st_data_s;
    logic [XLEN/8-1:0] st_strb_s;
    logic [XLEN-1:0]  ld_data_s;

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_func3  (req_func3),
        .st_offset (req_addr[OFF_W-1:0]),
        .st_wdata  (req_wdata),
        .st_data   (st_data_s),
        .st_strb   (st_strb_s),
        .ld_func3  (func3_r),
        .ld_offset (addr_r[OFF_W-1:0]),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_data_s)
    );

    // Request screening: legality first, then natural alignment
    always_comb begin
        size_s        = f3_size(req_func3);
        legal_s       = f3_legal(req_func3, req_is_store, XLEN == 64);
        misalign_s    = |(req_addr[OFF_W-1:0] & OFF_W'((4'd1 << size_s) - 4'd1));
        fault_s       = ~legal_s | misalign_s;
        timeout_hit_s = (TIMEOUT > 0) && (cnt_r == TO_LAST);
    end

    // Hold upstream while busy, and in the very cycle a faulting request is presented
    assign stall = rst & ((state_r != ST_IDLE) | (req_valid & (state_r == ST_IDLE) & fault_s));

    // FSM, timeout counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            is_store_r <= 1'b0;
            func3_r    <= 3'b000;
            addr_r     <= '0;
            rd_r       <= 5'd0;
            req_ready  <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
            exc_valid  <= 1'b0;
            exc_cause  <= 4'd0;
            exc_addr   <= '0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!legal_s) begin
                            exc_valid <= 1'b1;
                            exc_cause <= EXC_ILLEGAL;
                            exc_addr  <= req_addr;
                        end else if (misalign_s) begin
                            exc_valid <= 1'b1;
                            exc_cause <= req_is_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                            exc_addr  <= req_addr;
                        end else begin
                            state_r    <= ST_ACCESS;
                            req_ready  <= 1'b0;
                            cnt_r      <= '0;
                            is_store_r <= req_is_store;
                            func3_r    <= req_func3;
                            addr_r     <= req_addr;
                            rd_r       <= req_rd;
                            mem_addr   <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata  <= st_data_s;
                            mem_wstrb  <= req_is_store ? st_strb_s : '0;
                            mem_rd_en  <= ~req_is_store;
                            mem_wr_en  <= req_is_store;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        state_r   <= ST_IDLE;
                        req_ready <= 1'b1;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                        if (!is_store_r) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_r;
                            wb_data  <= ld_data_s;
                        end
                    end else if (timeout_hit_s) begin
                        state_r   <= ST_IDLE;
                        req_ready <= 1'b1;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                        exc_valid <= 1'b1;
                        exc_cause <= is_store_r ? EXC_ST_FAULT : EXC_LD_FAULT;
                        exc_addr  <= addr_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: vector table with a writeback/exception scoreboard on a 32-bit
// instance, plus timeout, idle-ready, reset-abort and 64-bit lane sequences.
module tb_load_store_unit;

    logic clk_s = 1'b0;
    logic rst_s;
    always #5 clk_s = ~clk_s;

    // 32-bit instance, short timeout
    logic        req_valid_s, req_ready_s, req_is_store_s, stall_s;
    logic [2:0]  req_func3_s;
    logic [31:0] req_addr_s, req_wdata_s, mem_addr_s, mem_wdata_s, mem_rdata_s;
    logic [31:0] wb_data_s, exc_addr_s;
    logic [4:0]  req_rd_s, wb_rd_s;
    logic [3:0]  mem_wstrb_s, exc_cause_s;
    logic        mem_rd_en_s, mem_wr_en_s, mem_ready_s, wb_valid_s, exc_valid_s;

    // 64-bit instance
    logic        req_valid64_s, req_ready64_s, req_is_store64_s, stall64_s;
    logic [2:0]  req_func364_s;
    logic [63:0] req_addr64_s, req_wdata64_s, mem_addr64_s, mem_wdata64_s, mem_rdata64_s;
    logic [63:0] wb_data64_s, exc_addr64_s;
    logic [4:0]  req_rd64_s, wb_rd64_s;
    logic [7:0]  mem_wstrb64_s;
    logic [3:0]  exc_cause64_s;
    logic        mem_rd_en64_s, mem_wr_en64_s, mem_ready64_s, wb_valid64_s, exc_valid64_s;

    load_store_unit #(.XLEN(32), .TIMEOUT(8)) u_dut (
        .clk(clk_s), .rst(rst_s),
        .req_valid(req_valid_s), .req_ready(req_ready_s), .req_is_store(req_is_store_s),
        .req_func3(req_func3_s), .req_addr(req_addr_s), .req_wdata(req_wdata_s), .req_rd(req_rd_s),
        .stall(stall_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_wstrb(mem_wstrb_s),
        .mem_rd_en(mem_rd_en_s), .mem_wr_en(mem_wr_en_s), .mem_ready(mem_ready_s),
        .mem_rdata(mem_rdata_s), .wb_valid(wb_valid_s), .wb_rd(wb_rd_s), .wb_data(wb_data_s),
        .exc_valid(exc_valid_s), .exc_cause(exc_cause_s), .exc_addr(exc_addr_s)
    );

    load_store_unit #(.XLEN(64), .TIMEOUT(16)) u_dut64 (
        .clk(clk_s), .rst(rst_s),
        .req_valid(req_valid64_s), .req_ready(req_ready64_s), .req_is_store(req_is_store64_s),
        .req_func3(req_func364_s), .req_addr(req_addr64_s), .req_wdata(req_wdata64_s),
        .req_rd(req_rd64_s), .stall(stall64_s), .mem_addr(mem_addr64_s),
        .mem_wdata(mem_wdata64_s), .mem_wstrb(mem_wstrb64_s), .mem_rd_en(mem_rd_en64_s),
        .mem_wr_en(mem_wr_en64_s), .mem_ready(mem_ready64_s), .mem_rdata(mem_rdata64_s),
        .wb_valid(wb_valid64_s), .wb_rd(wb_rd64_s), .wb_data(wb_data64_s),
        .exc_valid(exc_valid64_s), .exc_cause(exc_cause64_s), .exc_addr(exc_addr64_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_exc;
        logic [3:0]  cause;
        logic [31:0] value;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] maddr;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        logic [31:0] wb;
    } vec_t;

    exp_t sb_q[$];
    int   wb_seen = 0;

    // Scoreboard: every writeback or exception pulse must match the oldest expectation
    always @(negedge clk_s) begin : monitor
        exp_t e;
        if (rst_s && (wb_valid_s || exc_valid_s)) begin
            check("wb_exc_exclusive", 64'(wb_valid_s & exc_valid_s), 64'd0);
            if (wb_valid_s) wb_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'({wb_valid_s, exc_valid_s}), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_kind", 64'(exc_valid_s), 64'(e.is_exc));
                if (e.is_exc) begin
                    check("exc_cause", 64'(exc_cause_s), 64'(e.cause));
                    check("exc_addr", 64'(exc_addr_s), 64'(e.value));
                end else begin
                    check("wb_data", 64'(wb_data_s), 64'(e.value));
                    check("wb_rd", 64'(wb_rd_s), 64'(e.rd));
                end
            end
        end
    end

    // Called on a negedge; returns on the negedge where the next request may be presented
    task automatic run_vec(input vec_t v, input logic [4:0] rd);
        exp_t e;
        req_valid_s    = 1'b1;
        req_is_store_s = v.st;
        req_func3_s    = v.f3;
        req_addr_s     = v.addr;
        req_wdata_s    = v.wdata;
        req_rd_s       = rd;
        if (v.exc) begin
            e = '{is_exc: 1'b1, cause: v.cause, value: v.addr, rd: 5'd0};
            sb_q.push_back(e);
        end else if (!v.st) begin
            e = '{is_exc: 1'b0, cause: 4'd0, value: v.wb, rd: rd};
            sb_q.push_back(e);
        end
        #1;
        check("req_ready_idle", 64'(req_ready_s), 64'd1);
        check("stall_c0", 64'(stall_s), 64'(v.exc));
        @(posedge clk_s);
        #1;
        req_valid_s = 1'b0;
        @(negedge clk_s);
        if (v.exc) begin
            check("no_enable_on_fault", 64'({mem_rd_en_s, mem_wr_en_s}), 64'd0);
        end else begin
            check("enables", 64'({mem_rd_en_s, mem_wr_en_s}), 64'({~v.st, v.st}));
            check("mem_addr", 64'(mem_addr_s), 64'(v.maddr));
            check("stall_access", 64'(stall_s), 64'd1);
            if (v.st) begin
                check("mem_wstrb", 64'(mem_wstrb_s), 64'(v.strb));
                check("mem_wdata", 64'(mem_wdata_s), 64'(v.mwdata));
            end
            mem_ready_s = 1'b1;
            mem_rdata_s = v.rdata;
            @(posedge clk_s);
            #1;
            mem_ready_s = 1'b0;
            mem_rdata_s = 32'h5A5A_5A5A;
            @(negedge clk_s);
            check("enables_drop", 64'({mem_rd_en_s, mem_wr_en_s}), 64'd0);
            check("req_ready_back", 64'(req_ready_s), 64'd1);
        end
    endtask

    task automatic run64(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic [63:0] maddr, input logic [7:0] strb,
                         input logic [63:0] mwdata, input logic [63:0] wb);
        req_valid64_s    = 1'b1;
        req_is_store64_s = st;
        req_func364_s    = f3;
        req_addr64_s     = addr;
        req_wdata64_s    = wdata;
        req_rd64_s       = 5'd3;
        @(posedge clk_s);
        #1;
        req_valid64_s = 1'b0;
        @(negedge clk_s);
        check("x64_enables", 64'({mem_rd_en64_s, mem_wr_en64_s}), 64'({~st, st}));
        check("x64_mem_addr", mem_addr64_s, maddr);
        if (st) begin
            check("x64_wstrb", 64'(mem_wstrb64_s), 64'(strb));
            check("x64_wdata", mem_wdata64_s, mwdata);
        end
        mem_ready64_s = 1'b1;
        mem_rdata64_s = rdata;
        @(posedge clk_s);
        #1;
        mem_ready64_s = 1'b0;
        mem_rdata64_s = 64'h0;
        @(negedge clk_s);
        check("x64_wb_valid", 64'({wb_valid64_s, exc_valid64_s}), 64'({~st, 1'b0}));
        if (!st) check("x64_wb_data", wb_data64_s, wb);
    endtask

    vec_t vecs[15];

    initial begin
        int   n;
        int   w0;
        exp_t e;
        vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 4'd0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1'b0, 4'd0, 32'h100, 4'b0, 32'h0, 32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1'b0, 4'd0, 32'h100, 4'b0, 32'h0, 32'h00000080};
        vecs[3]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 1'b0, 4'd0, 32'h200, 4'b1100, 32'hABCD0000, 32'h0};
        vecs[4]  = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 1'b1, 4'd4, 32'h0, 4'b0, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 4'd6, 32'h0, 4'b0, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1'b0, 4'd0, 32'h100, 4'b0, 32'h0, 32'hFFFF8001};
        vecs[7]  = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 1'b0, 4'd0, 32'h100, 4'b0, 32'h0, 32'h00008001};
        vecs[8]  = '{1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 1'b0, 4'd0, 32'h104, 4'b0, 32'h0, 32'h12345678};
        vecs[9]  = '{1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 1'b0, 4'd0, 32'h300, 4'b0010, 32'h0000A500, 32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h108, 32'h0, 32'h0, 1'b1, 4'd2, 32'h0, 4'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 3'b100, 32'h110, 32'h0, 32'h0, 1'b1, 4'd2, 32'h0, 4'b0, 32'h0, 32'h0};
        vecs[12] = '{1'b0, 3'b110, 32'h114, 32'h0, 32'h0, 1'b1, 4'd2, 32'h0, 4'b0, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 3'b111, 32'h118, 32'h0, 32'h0, 1'b1, 4'd2, 32'h0, 4'b0, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 3'b000, 32'h200, 32'h0, 32'h0000007F, 1'b0, 4'd0, 32'h200, 4'b0, 32'h0, 32'h0000007F};

        req_valid_s = 1'b0; req_is_store_s = 1'b0; req_func3_s = 3'b000;
        req_addr_s = 32'h0; req_wdata_s = 32'h0; req_rd_s = 5'd0;
        mem_ready_s = 1'b0; mem_rdata_s = 32'h5A5A_5A5A;
        req_valid64_s = 1'b0; req_is_store64_s = 1'b0; req_func364_s = 3'b000;
        req_addr64_s = 64'h0; req_wdata64_s = 64'h0; req_rd64_s = 5'd0;
        mem_ready64_s = 1'b0; mem_rdata64_s = 64'h0;

        rst_s = 1'b1;
        #2 rst_s = 1'b0;
        repeat (2) @(negedge clk_s);
        check("rst_req_ready", 64'(req_ready_s), 64'd1);
        check("rst_stall", 64'(stall_s), 64'd0);
        check("rst_enables", 64'({mem_rd_en_s, mem_wr_en_s}), 64'd0);
        check("rst_pulses", 64'({wb_valid_s, exc_valid_s}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_s), 64'd0);
        check("rst_wstrb", 64'(mem_wstrb_s), 64'd0);
        rst_s = 1'b1;
        @(negedge clk_s);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], 5'(i + 1));
        end

        // Load timeout: exactly 8 access cycles, then cause 5 with enables already low
        e = '{is_exc: 1'b1, cause: 4'd5, value: 32'h40, rd: 5'd0};
        sb_q.push_back(e);
        req_valid_s = 1'b1; req_is_store_s = 1'b0; req_func3_s = 3'b010; req_addr_s = 32'h40;
        @(posedge clk_s);
        #1 req_valid_s = 1'b0;
        n = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk_s);
            if (!mem_rd_en_s) break;
            n++;
        end
        check("ld_timeout_cycles", 64'(n), 64'd8);
        check("ld_timeout_ready", 64'(req_ready_s), 64'd1);
        check("ld_timeout_pulse", 64'(exc_valid_s), 64'd1);

        // Store timeout reports cause 7
        e = '{is_exc: 1'b1, cause: 4'd7, value: 32'h44, rd: 5'd0};
        sb_q.push_back(e);
        req_valid_s = 1'b1; req_is_store_s = 1'b1; req_func3_s = 3'b010; req_addr_s = 32'h44;
        @(posedge clk_s);
        #1 req_valid_s = 1'b0;
        n = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk_s);
            if (!mem_wr_en_s) break;
            n++;
        end
        check("st_timeout_cycles", 64'(n), 64'd8);

        // mem_ready while idle must be ignored
        w0 = wb_seen;
        mem_ready_s = 1'b1; mem_rdata_s = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk_s);
        mem_ready_s = 1'b0;
        @(negedge clk_s);
        check("idle_ready_ignored", 64'(wb_seen), 64'(w0));

        // Asynchronous reset mid-access abandons the load silently
        req_valid_s = 1'b1; req_is_store_s = 1'b0; req_func3_s = 3'b010; req_addr_s = 32'h80;
        @(posedge clk_s);
        #1 req_valid_s = 1'b0;
        @(negedge clk_s);
        check("pre_reset_rd_en", 64'(mem_rd_en_s), 64'd1);
        #2 rst_s = 1'b0;
        #1;
        check("async_rd_en_low", 64'(mem_rd_en_s), 64'd0);
        check("async_stall_low", 64'(stall_s), 64'd0);
        check("async_req_ready", 64'(req_ready_s), 64'd1);
        @(negedge clk_s);
        rst_s = 1'b1;
        mem_ready_s = 1'b1; mem_rdata_s = 32'h1234_5678;
        repeat (2) @(negedge clk_s);
        mem_ready_s = 1'b0;
        repeat (3) @(negedge clk_s);
        check("no_wb_after_reset", 64'(wb_seen), 64'(w0));
        check("post_reset_ready", 64'(req_ready_s), 64'd1);

        // 64-bit lanes
        run64(1'b0, 3'b011, 64'h08, 64'h0, 64'h8123_4567_89AB_CDEF, 64'h08, 8'h00, 64'h0, 64'h8123_4567_89AB_CDEF);
        run64(1'b0, 3'b010, 64'h0C, 64'h0, 64'h8000_0000_1111_1111, 64'h08, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000);
        run64(1'b0, 3'b110, 64'h0C, 64'h0, 64'h8000_0000_1111_1111, 64'h08, 8'h00, 64'h0, 64'h0000_0000_8000_0000);
        run64(1'b1, 3'b011, 64'h10, 64'h0102_0304_0506_0708, 64'h0, 64'h10, 8'hFF, 64'h0102_0304_0506_0708, 64'h0);
        run64(1'b1, 3'b010, 64'h14, 64'hCAFE_BABE, 64'h0, 64'h10, 8'hF0, 64'hCAFE_BABE_0000_0000, 64'h0);

        repeat (2) @(negedge clk_s);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
